// File: rtl/seq_onehot_scan_encoder.sv
// Sequential set-bit encoder: captures an N-bit request vector and streams out the
// index of each set bit, one per output handshake, LSB-first or MSB-first.
module seq_onehot_scan_encoder #(
  parameter int unsigned N         = 8,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [N-1:0]               d,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(N)-1:0]       y,
  output logic                       out_last,
  output logic [$clog2(N):0]         count,
  output logic                       none
);

  localparam int unsigned W = $clog2(N);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  state_t         state, state_nxt;
  logic [N-1:0]   pending, pending_nxt;
  logic [W-1:0]   y_nxt;
  logic           out_valid_nxt, out_last_nxt, none_nxt;
  logic [W:0]     count_nxt;
  logic [N-1:0]   remaining;
  logic           accept;

  function automatic logic [W:0] popcnt(input logic [N-1:0] v);
    logic [W:0] c;
    c = '0;
    for (int unsigned i = 0; i < N; i++) begin
      c = c + (W+1)'(v[i]);
    end
    return c;
  endfunction

  // Later loop iterations win, so the walk direction is the reverse of scan order.
  function automatic logic [W-1:0] first_bit(input logic [N-1:0] v);
    logic [W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (MSB_FIRST) begin
        if (v[i]) idx = W'(i);
      end else begin
        if (v[N-1-i]) idx = W'(N-1-i);
      end
    end
    return idx;
  endfunction

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;

  always_comb begin
    remaining = '0;
    for (int unsigned i = 0; i < N; i++) begin
      remaining[i] = pending[i] && (W'(i) != y);
    end
  end

  always_comb begin
    state_nxt     = state;
    pending_nxt   = pending;
    y_nxt         = y;
    out_valid_nxt = out_valid;
    out_last_nxt  = out_last;
    count_nxt     = count;
    none_nxt      = 1'b0;
    unique case (state)
      IDLE: begin
        if (accept) begin
          if (d != '0) begin
            pending_nxt   = d;
            count_nxt     = popcnt(d);
            y_nxt         = first_bit(d);
            out_last_nxt  = (popcnt(d) == (W+1)'(1));
            out_valid_nxt = 1'b1;
            state_nxt     = SCAN;
          end else begin
            none_nxt  = 1'b1;
            count_nxt = '0;
          end
        end
      end
      SCAN: begin
        if (out_valid && out_ready) begin
          pending_nxt = remaining;
          if (out_last) begin
            out_valid_nxt = 1'b0;
            out_last_nxt  = 1'b0;
            state_nxt     = IDLE;
          end else begin
            y_nxt        = first_bit(remaining);
            out_last_nxt = (popcnt(remaining) == (W+1)'(1));
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pending   <= '0;
      y         <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      count     <= '0;
      none      <= 1'b0;
    end else begin
      state     <= state_nxt;
      pending   <= pending_nxt;
      y         <= y_nxt;
      out_valid <= out_valid_nxt;
      out_last  <= out_last_nxt;
      count     <= count_nxt;
      none      <= none_nxt;
    end
  end

endmodule

// File: tb/tb_seq_onehot_scan_encoder.sv
// Directed bench for seq_onehot_scan_encoder: an LSB-first and an MSB-first instance
// share clock and reset; inputs change and outputs are sampled on the falling edge.
module tb_seq_onehot_scan_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       l_in_valid = 1'b0, l_in_ready, l_out_valid, l_out_ready = 1'b0;
  logic [7:0] l_d = '0;
  logic [2:0] l_y;
  logic       l_out_last, l_none;
  logic [3:0] l_count;

  logic       m_in_valid = 1'b0, m_in_ready, m_out_valid, m_out_ready = 1'b0;
  logic [7:0] m_d = '0;
  logic [2:0] m_y;
  logic       m_out_last, m_none;
  logic [3:0] m_count;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clk = ~clk;

  seq_onehot_scan_encoder #(.N(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst_n(rst_n), .in_valid(l_in_valid), .in_ready(l_in_ready), .d(l_d),
    .out_valid(l_out_valid), .out_ready(l_out_ready), .y(l_y), .out_last(l_out_last),
    .count(l_count), .none(l_none)
  );

  seq_onehot_scan_encoder #(.N(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .rst_n(rst_n), .in_valid(m_in_valid), .in_ready(m_in_ready), .d(m_d),
    .out_valid(m_out_valid), .out_ready(m_out_ready), .y(m_y), .out_last(m_out_last),
    .count(m_count), .none(m_none)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Offer d to the LSB instance for one cycle; returns on the cycle after the accept.
  task automatic send_lsb(input logic [7:0] v);
    l_d        = v;
    l_in_valid = 1'b1;
    step();
    l_in_valid = 1'b0;
    l_d        = 8'h5A;
  endtask

  initial begin
    int unsigned hs;

    step();
    check_eq("rst out_valid", l_out_valid, 0);
    check_eq("rst y", l_y, 0);
    check_eq("rst out_last", l_out_last, 0);
    check_eq("rst count", l_count, 0);
    check_eq("rst none", l_none, 0);
    check_eq("rst in_ready", l_in_ready, 1);
    rst_n = 1'b1;
    step();

    // 1) single bit
    l_out_ready = 1'b1;
    send_lsb(8'b0000_0001);
    check_eq("t1 out_valid", l_out_valid, 1);
    check_eq("t1 y", l_y, 0);
    check_eq("t1 last", l_out_last, 1);
    check_eq("t1 count", l_count, 1);
    check_eq("t1 in_ready busy", l_in_ready, 0);
    step();
    check_eq("t1 done valid", l_out_valid, 0);
    check_eq("t1 done ready", l_in_ready, 1);

    // 2) LSB-first 10010100
    send_lsb(8'b1001_0100);
    check_eq("t2 y0", l_y, 2);
    check_eq("t2 last0", l_out_last, 0);
    check_eq("t2 count", l_count, 3);
    step();
    check_eq("t2 y1", l_y, 4);
    check_eq("t2 last1", l_out_last, 0);
    check_eq("t2 valid1", l_out_valid, 1);
    step();
    check_eq("t2 y2", l_y, 7);
    check_eq("t2 last2", l_out_last, 1);
    step();
    check_eq("t2 end valid", l_out_valid, 0);
    check_eq("t2 end ready", l_in_ready, 1);
    check_eq("t2 y hold", l_y, 7);

    // 3) MSB-first, same vector
    m_out_ready = 1'b1;
    m_d         = 8'b1001_0100;
    m_in_valid  = 1'b1;
    step();
    m_in_valid  = 1'b0;
    m_d         = 8'hFF;
    check_eq("t3 y0", m_y, 7);
    check_eq("t3 last0", m_out_last, 0);
    check_eq("t3 count", m_count, 3);
    step();
    check_eq("t3 y1", m_y, 4);
    check_eq("t3 last1", m_out_last, 0);
    step();
    check_eq("t3 y2", m_y, 2);
    check_eq("t3 last2", m_out_last, 1);
    step();
    check_eq("t3 end valid", m_out_valid, 0);

    // 4) all ones with backpressure
    l_out_ready = 1'b0;
    send_lsb(8'hFF);
    check_eq("t4 count", l_count, 8);
    for (int i = 0; i < 3; i++) begin
      check_eq("t4 stall y", l_y, 0);
      check_eq("t4 stall valid", l_out_valid, 1);
      if (i < 2) step();
    end
    l_out_ready = 1'b1;
    hs = 0;
    for (int k = 0; k < 8; k++) begin
      check_eq("t4 y", l_y, k);
      check_eq("t4 last", l_out_last, (k == 7) ? 1 : 0);
      if (l_out_valid && l_out_ready) hs++;
      step();
    end
    check_eq("t4 handshakes", hs, 8);
    check_eq("t4 end valid", l_out_valid, 0);

    // 5) all-zero vector
    send_lsb(8'h00);
    check_eq("t5 none", l_none, 1);
    check_eq("t5 out_valid", l_out_valid, 0);
    check_eq("t5 in_ready", l_in_ready, 1);
    check_eq("t5 count", l_count, 0);
    step();
    check_eq("t5 none pulse", l_none, 0);
    check_eq("t5 valid after", l_out_valid, 0);

    // 6) reset mid-scan
    l_out_ready = 1'b0;
    send_lsb(8'hA0);
    check_eq("t6 y first", l_y, 5);
    check_eq("t6 count", l_count, 2);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6 rst valid", l_out_valid, 0);
    check_eq("t6 rst y", l_y, 0);
    check_eq("t6 rst count", l_count, 0);
    check_eq("t6 rst last", l_out_last, 0);
    step();
    rst_n = 1'b1;
    step();
    check_eq("t6 in_ready", l_in_ready, 1);
    l_out_ready = 1'b1;
    send_lsb(8'h08);
    check_eq("t6 new y", l_y, 3);
    check_eq("t6 new last", l_out_last, 1);
    check_eq("t6 new valid", l_out_valid, 1);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
